board_reset_ctrl: RTL and testbench
===================================

Name: board_reset_ctrl

Overview:
- Board-level clock-enable and reset sequencer that sits directly upstream of the Grande_Risco_5_SOC instance in each FPGA top.
- Replaces the free-running divider and raw button wiring:
  - synchronizes and debounces the board reset button;
  - generates the divided SoC clock and a matching single-cycle enable;
  - releases the SoC's active-low reset only after a fixed number of divided-clock cycles, aligned to a divided-clock edge.
- Also exports a saturating count of button-initiated resets for LED/debug display.

Parameters:
- CLK_DIV, 2, board-clock cycles per divided-clock period; even, >= 2.
- DEBOUNCE_CYCLES, 65536, consecutive stable synchronized samples needed to accept a new button level; >= 2.
- HOLD_CYCLES, 16, divided-clock cycles for which soc_rst_n stays low after the button is accepted as released; >= 1.
- SYNC_STAGES, 2, flip-flops in the button synchronizer; >= 2.

Ports:
- clk  input  1  board clock (e.g. 100 MHz).
- rst  input  1  asynchronous, active-high reset for the whole block (e.g. inverted MMCM locked).
- btn_rst_n  input  1  raw, asynchronous, bouncing reset button; 0 = pressed.
- clk_div  output  1  divided clock for the SoC; high for the first CLK_DIV/2 counts of each period.
- clk_en  output  1  one-clk pulse in the last board cycle of each divided period.
- soc_rst_n  output  1  active-low SoC reset; connects to the SOC rst_n.
- rst_active  output  1  1 whenever the FSM is not in S_RUN.
- reset_count  output  8  saturating count of S_RUN -> S_ASSERT transitions.

Behaviour:
- Reset values on rst=1, applied asynchronously:
  - outputs: clk_div=0, clk_en=0, soc_rst_n=0, rst_active=1, reset_count=0;
  - internal state: synchronizer stages=0 (treated as pressed), stable level=0, all counters=0, state=S_ASSERT.
- Synchronizer: a SYNC_STAGES shift chain samples btn_rst_n; only the last stage feeds the debouncer.
- Debouncer:
  - When the synced level equals the stable level, deb_cnt is cleared to 0.
  - When they differ, deb_cnt increments. When deb_cnt == DEBOUNCE_CYCLES-1, the stable level takes the synced value and deb_cnt returns to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- Divider:
  - div_cnt wraps 0..CLK_DIV-1 and is free-running once rst is low.
  - All outputs are registered: clk_div = (div_cnt < CLK_DIV/2), clk_en = (div_cnt == CLK_DIV-1).
- FSM (state encoding in the package):
  - S_ASSERT: soc_rst_n=0. When stable==1 (button released), go to S_HOLD and clear hold_cnt.
  - S_HOLD: soc_rst_n=0. On each clk_en cycle, hold_cnt increments.
    - If stable==0, return to S_ASSERT. This check has priority over everything else.
    - When clk_en=1 and hold_cnt == HOLD_CYCLES-1, go to S_RUN. soc_rst_n rises in that same registered update, so release always coincides with a clk_en cycle.
  - S_RUN: soc_rst_n=1. When stable==0, go to S_ASSERT.
    - soc_rst_n falls on the next clk edge; no alignment to the divided clock is required.
    - reset_count increments, saturating at 255.
- rst_active = (state != S_RUN), registered alongside soc_rst_n.
- Boundary cases:
  - Button pressed while in S_HOLD: no reset_count increment, and hold_cnt restarts from 0 on the next release.
  - rst asserted mid-operation: immediate return to the reset values, including reset_count=0.
  - Button held pressed indefinitely: the block stays in S_ASSERT, while clk_div/clk_en keep running.

Decomposition:
- Package board_reset_pkg:
  - typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RUN} rst_state_t;
  - localparam RESET_COUNT_W = 8.
- Sub-module button_debouncer (parameters SYNC_STAGES and DEBOUNCE_CYCLES; ports clk, rst, din, dout): contains the synchronizer and the debounce counter.
- Divider and FSM live in board_reset_ctrl.

Test Plan (CLK_DIV=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, SYNC_STAGES=2 unless stated):
- Power-up: rst=1 for 5 cycles with btn_rst_n=1, then release -> soc_rst_n stays 0 for at least 12 clk cycles, then rises on a cycle where clk_en=1; rst_active falls in the same cycle; reset_count=0.
- Divider: CLK_DIV=4, free run for 40 cycles -> clk_div pattern 1100 repeating; clk_en high exactly once per 4 cycles, in the cycle with div_cnt=3.
- Bounce rejection: in S_RUN, pulse btn_rst_n low for 3 cycles -> soc_rst_n stays 1 and reset_count stays 0. Pulse it low for 8 cycles -> soc_rst_n falls within 2+4+1 cycles of the falling edge, and reset_count=1.
- Press during hold: release the button, then press it again after 1 clk_en pulse in S_HOLD -> back to S_ASSERT with soc_rst_n never high and reset_count unchanged. A final release yields a full 3-pulse hold before soc_rst_n rises.
- Saturation: 260 debounced press/release cycles -> reset_count reads 255 and does not wrap.
- Mid-run reset: assert rst asynchronously between clk edges while in S_RUN -> soc_rst_n=0, clk_div=0 and reset_count=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/board_reset_pkg.sv
// Shared types and constants for the board reset sequencer.
package board_reset_pkg;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_HOLD,
    S_RUN
  } rst_state_t;

  localparam int unsigned RESET_COUNT_W = 8;

endpackage

// File: rtl/board_reset_ctrl_button_debouncer.sv
// Button synchronizer followed by a consecutive-sample debounce filter.
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DebW-1:0]        deb_cnt_q;
  logic                   stable_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign dout   = stable_q;

  // Stages reset to 0 so the button reads as pressed until proven otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      stable_q  <= 1'b0;
    end else if (synced == stable_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DebLast) begin
      deb_cnt_q <= '0;
      stable_q  <= synced;
    end else begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/board_reset_ctrl.sv
// Divided SoC clock/enable generator and debounced reset sequencer for the SoC.
module board_reset_ctrl
  import board_reset_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_rst_n,
  output logic                     clk_div,
  output logic                     clk_en,
  output logic                     soc_rst_n,
  output logic                     rst_active,
  output logic [RESET_COUNT_W-1:0] reset_count
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(CLK_DIV / 2);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic                     stable;
  logic [DivW-1:0]          div_cnt_q, div_cnt_d;
  logic                     clk_div_q, clk_en_q, en_next;
  logic [HoldW-1:0]         hold_cnt_q;
  rst_state_t               state_q;
  logic                     soc_rst_n_q, rst_active_q;
  logic [RESET_COUNT_W-1:0] reset_count_q;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk (clk),
    .rst (rst),
    .din (btn_rst_n),
    .dout(stable)
  );

  always_comb begin
    div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
    en_next   = (div_cnt_d == DivLast);
  end

  // Outputs are decoded from the next count so they line up with div_cnt_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      clk_div_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_div_q <= (div_cnt_d < DivHalf);
      clk_en_q  <= en_next;
    end
  end

  // Hold advances on the update that raises clk_en, so release lands in an enable cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ASSERT;
      hold_cnt_q    <= '0;
      soc_rst_n_q   <= 1'b0;
      rst_active_q  <= 1'b1;
      reset_count_q <= '0;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          if (stable) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (!stable) begin
            state_q <= S_ASSERT;
          end else if (en_next) begin
            if (hold_cnt_q == HoldLast) begin
              state_q      <= S_RUN;
              soc_rst_n_q  <= 1'b1;
              rst_active_q <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!stable) begin
            state_q      <= S_ASSERT;
            soc_rst_n_q  <= 1'b0;
            rst_active_q <= 1'b1;
            if (reset_count_q != '1) begin
              reset_count_q <= reset_count_q + 1'b1;
            end
          end
        end
        default: begin
          state_q      <= S_ASSERT;
          soc_rst_n_q  <= 1'b0;
          rst_active_q <= 1'b1;
        end
      endcase
    end
  end

  assign clk_div     = clk_div_q;
  assign clk_en      = clk_en_q;
  assign soc_rst_n   = soc_rst_n_q;
  assign rst_active  = rst_active_q;
  assign reset_count = reset_count_q;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Directed bench for board_reset_ctrl: sequencing, divider, debounce, saturation, async reset.
module tb_board_reset_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_rst_n;
  logic       clk_div, clk_en, soc_rst_n, rst_active;
  logic [7:0] reset_count;
  logic       d4_clk_div, d4_clk_en, d4_soc_rst_n, d4_rst_active;
  logic [7:0] d4_reset_count;

  int errors = 0;
  int checks = 0;

  board_reset_ctrl #(
    .CLK_DIV        (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (3),
    .SYNC_STAGES    (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .btn_rst_n  (btn_rst_n),
    .clk_div    (clk_div),
    .clk_en     (clk_en),
    .soc_rst_n  (soc_rst_n),
    .rst_active (rst_active),
    .reset_count(reset_count)
  );

  board_reset_ctrl #(
    .CLK_DIV        (4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (3),
    .SYNC_STAGES    (2)
  ) u_dut_div4 (
    .clk        (clk),
    .rst        (rst),
    .btn_rst_n  (btn_rst_n),
    .clk_div    (d4_clk_div),
    .clk_en     (d4_clk_en),
    .soc_rst_n  (d4_soc_rst_n),
    .rst_active (d4_rst_active),
    .reset_count(d4_reset_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One board edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int rise_k, fall_k, en_at_rise, act_at_rise, pulses, k;
    logic saw_high, saw_low;

    rst       = 1'b1;
    btn_rst_n = 1'b1;
    #1;
    check("reset_soc_rst_n", soc_rst_n, 0);
    check("reset_rst_active", rst_active, 1);
    check("reset_clk_div", clk_div, 0);
    check("reset_clk_en", clk_en, 0);
    check("reset_count_init", reset_count, 0);
    repeat (5) step();
    rst = 1'b0;

    // Power-up release and divide-by-4 pattern, sampled after each edge k.
    rise_k = -1; en_at_rise = 0; act_at_rise = 1;
    for (int i = 1; i <= 40; i++) begin
      step();
      check("div4_clk_div", d4_clk_div, ((i % 4) < 2) ? 1 : 0);
      check("div4_clk_en", d4_clk_en, ((i % 4) == 3) ? 1 : 0);
      if (rise_k < 0 && soc_rst_n) begin
        rise_k      = i;
        en_at_rise  = clk_en;
        act_at_rise = rst_active;
      end
    end
    check("pwrup_rise_cycle", rise_k, 13);
    check("pwrup_rise_clk_en", en_at_rise, 1);
    check("pwrup_rise_rst_active", act_at_rise, 0);
    check("pwrup_count", reset_count, 0);

    // Three-cycle glitch is too short to be accepted.
    btn_rst_n = 1'b0;
    repeat (3) step();
    btn_rst_n = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!soc_rst_n) saw_low = 1'b1;
    end
    check("glitch_soc_low_seen", saw_low, 0);
    check("glitch_count", reset_count, 0);

    // Eight-cycle press: 2 sync + 4 debounce + 1 FSM.
    btn_rst_n = 1'b0;
    fall_k = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (fall_k < 0 && !soc_rst_n) fall_k = i;
    end
    btn_rst_n = 1'b1;
    check("press_fall_cycle", fall_k, 7);
    check("press_count", reset_count, 1);
    check("press_rst_active", rst_active, 1);
    k = 0;
    while (!soc_rst_n && k < 30) begin
      step();
      k++;
    end
    check("press_rerun", soc_rst_n, 1);

    // Press, release, then press again while in hold.
    btn_rst_n = 1'b0;
    repeat (12) step();
    check("hold_pre_count", reset_count, 2);
    btn_rst_n = 1'b1;
    repeat (5) step();
    btn_rst_n = 1'b0;
    saw_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (soc_rst_n) saw_high = 1'b1;
    end
    check("hold_abort_soc_high_seen", saw_high, 0);
    check("hold_abort_count", reset_count, 2);
    btn_rst_n = 1'b1;
    rise_k = -1; pulses = 0; en_at_rise = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (rise_k < 0) begin
        if (i >= 8 && clk_en) pulses++;
        if (soc_rst_n) begin
          rise_k     = i;
          en_at_rise = clk_en;
        end
      end
    end
    check("hold_full_pulses", pulses, 3);
    check("hold_rise_clk_en", en_at_rise, 1);
    check("hold_rerun", soc_rst_n, 1);

    // Saturation of the reset counter.
    for (int i = 0; i < 260; i++) begin
      btn_rst_n = 1'b0;
      repeat (10) step();
      if (i == 100) check("sat_mid_count", reset_count, 103);
      btn_rst_n = 1'b1;
      repeat (16) step();
    end
    check("sat_count", reset_count, 255);
    check("sat_running", soc_rst_n, 1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_soc_rst_n", soc_rst_n, 0);
    check("async_clk_div", clk_div, 0);
    check("async_count", reset_count, 0);
    check("async_rst_active", rst_active, 1);

    // Button held pressed through reset release: divider runs, SoC stays in reset.
    btn_rst_n = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    saw_high = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (soc_rst_n) saw_high = 1'b1;
      if (clk_en) pulses++;
    end
    check("held_soc_high_seen", saw_high, 0);
    check("held_clk_en_pulses", pulses, 10);
    check("held_count", reset_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
